// File: rtl/simple_in_debounce_pkg.sv
// Shared types and constants for the three-channel input debouncer.
// State encoding is fixed so it can be probed and compared directly.
package simple_io_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    WAIT_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

  localparam int CNT_W                   = 16;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  // The accepted level is high in ST_HIGH and while deciding whether to leave it.
  function automatic logic is_high_state(input db_state_e s);
    return (s == ST_HIGH) || (s == WAIT_LOW);
  endfunction

endpackage

// File: rtl/simple_in_debounce_if.sv
// One debounced channel: raw level in, accepted level and edge strobes out.
interface simple_in_debounce_if;
  // No valid/ready here: raw is sampled every clock, lvl is a level, and
  // rise/fall are single-clock strobes with no backpressure.
  logic raw;
  logic lvl;
  logic rise;
  logic fall;

  modport master (input raw, output lvl, output rise, output fall);
  modport slave  (output raw, input lvl, input rise, input fall);
endinterface

// File: rtl/simple_in_debounce_channel.sv
// Single debounce channel: 2-flop synchronizer, 4-state acceptance FSM
// with a saturating stability counter, registered level and edge strobes.
module debounce_channel
  import simple_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  simple_in_debounce_if.master   ch
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync_0;
  logic             sync_1;
  db_state_e        state_q;
  db_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             lvl_q;
  logic             lvl_d;
  logic             rise_q;
  logic             fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
    end else begin
      sync_0 <= ch.raw;
      sync_1 <= sync_0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only advances while waiting and is cleared on every
  // decision, so it tops out at CNT_LIMIT and never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (sync_1) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!sync_1) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!sync_1) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (sync_1) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign lvl_d = is_high_state(state_d);

  // Strobes are registered alongside lvl so they line up with its change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      rise_q <= lvl_d & ~lvl_q;
      fall_q <= ~lvl_d & lvl_q;
    end
  end

  assign ch.lvl  = lvl_q;
  assign ch.rise = rise_q;
  assign ch.fall = fall_q;

endmodule

// File: rtl/simple_in_debounce.sv
// Three independent debounced inputs plus a delayed any-edge summary strobe.
module simple_in_debounce
  import simple_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_1,
  input  logic in_2,
  input  logic in_3,
  output logic lvl_1,
  output logic lvl_2,
  output logic lvl_3,
  output logic rise_1,
  output logic rise_2,
  output logic rise_3,
  output logic fall_1,
  output logic fall_2,
  output logic fall_3,
  output logic any_change
);

  simple_in_debounce_if ch_if_1 ();
  simple_in_debounce_if ch_if_2 ();
  simple_in_debounce_if ch_if_3 ();

  assign ch_if_1.raw = in_1;
  assign ch_if_2.raw = in_2;
  assign ch_if_3.raw = in_3;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_1 (
    .clk(clk), .rst_n(rst_n), .ch(ch_if_1.master)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_2 (
    .clk(clk), .rst_n(rst_n), .ch(ch_if_2.master)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_3 (
    .clk(clk), .rst_n(rst_n), .ch(ch_if_3.master)
  );

  assign lvl_1  = ch_if_1.lvl;
  assign lvl_2  = ch_if_2.lvl;
  assign lvl_3  = ch_if_3.lvl;
  assign rise_1 = ch_if_1.rise;
  assign rise_2 = ch_if_2.rise;
  assign rise_3 = ch_if_3.rise;
  assign fall_1 = ch_if_1.fall;
  assign fall_2 = ch_if_2.fall;
  assign fall_3 = ch_if_3.fall;

  // Simultaneous edges on several channels collapse into one strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change <= 1'b0;
    end else begin
      any_change <= rise_1 | rise_2 | rise_3 | fall_1 | fall_2 | fall_3;
    end
  end

endmodule

// File: tb/tb_simple_in_debounce.sv
// Bench for simple_in_debounce with DEBOUNCE_CYCLES=4: directed scenarios
// plus random input traffic, all checked against a stable-run reference model.
module tb_simple_in_debounce;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in_v = 3'b000;
  logic       any_change;

  simple_in_debounce_if b1 ();
  simple_in_debounce_if b2 ();
  simple_in_debounce_if b3 ();

  assign b1.raw = in_v[0];
  assign b2.raw = in_v[1];
  assign b3.raw = in_v[2];

  simple_in_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_1(b1.raw), .in_2(b2.raw), .in_3(b3.raw),
    .lvl_1(b1.lvl), .lvl_2(b2.lvl), .lvl_3(b3.lvl),
    .rise_1(b1.rise), .rise_2(b2.rise), .rise_3(b3.rise),
    .fall_1(b1.fall), .fall_2(b2.fall), .fall_3(b3.fall),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  wire [2:0] lvl_v  = {b3.lvl, b2.lvl, b1.lvl};
  wire [2:0] rise_v = {b3.rise, b2.rise, b1.rise};
  wire [2:0] fall_v = {b3.fall, b2.fall, b1.fall};
  wire [9:0] dut_v  = {any_change, lvl_v, rise_v, fall_v};

  // Reference model: the input reaches the decision logic two clocks late;
  // a level is accepted once D+1 consecutive delayed samples disagree with it.
  logic [2:0] in_d1, in_d2;
  int         run [3];
  logic [2:0] m_lvl, m_rise, m_fall;
  logic       m_any;
  wire  [9:0] exp_v = {m_any, m_lvl, m_rise, m_fall};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_d1 <= '0; in_d2 <= '0;
      m_lvl <= '0; m_rise <= '0; m_fall <= '0; m_any <= 1'b0;
      for (int c = 0; c < 3; c++) run[c] <= 0;
    end else begin
      in_d1  <= in_v;
      in_d2  <= in_d1;
      m_any  <= |(m_rise | m_fall);
      m_rise <= '0;
      m_fall <= '0;
      for (int c = 0; c < 3; c++) begin
        if (in_d2[c] != m_lvl[c]) begin
          if (run[c] == D) begin
            m_lvl[c]  <= in_d2[c];
            m_rise[c] <= in_d2[c];
            m_fall[c] <= ~in_d2[c];
            run[c]    <= 0;
          end else begin
            run[c] <= run[c] + 1;
          end
        end else begin
          run[c] <= 0;
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_v  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (dut_v !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_state: got %b want %b", dut_v, 10'b0);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (dut_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: got %b want %b", i, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_rise_single();
    int rise_at = -1;
    int any_at  = -1;
    int any_cnt = 0;
    in_v[0] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_tests++;
      if (dut_v !== exp_v) begin
        n_fail++;
        $display("FAIL rise_single e%0d: got %b want %b", e, dut_v, exp_v);
      end
      if (b1.rise === 1'b1) rise_at = e;
      if (any_change === 1'b1) begin any_at = e; any_cnt++; end
    end
    n_tests++;
    if (rise_at !== 6 || b1.lvl !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_edge: rise at %0d lvl %b want 6 / 1", rise_at, b1.lvl);
    end
    n_tests++;
    if (any_at !== 7 || any_cnt !== 1) begin
      n_fail++;
      $display("FAIL rise_any: at %0d count %0d want 7 / 1", any_at, any_cnt);
    end
  endtask

  task automatic test_glitch();
    logic seen_rise = 1'b0;
    logic seen_lvl  = 1'b0;
    for (int e = 0; e < 18; e++) begin
      in_v[1] = (e < 3);
      tick();
      n_tests++;
      if (dut_v !== exp_v) begin
        n_fail++;
        $display("FAIL glitch e%0d: got %b want %b", e, dut_v, exp_v);
      end
      if (b2.rise === 1'b1) seen_rise = 1'b1;
      if (b2.lvl === 1'b1) seen_lvl = 1'b1;
    end
    n_tests++;
    if (seen_rise !== 1'b0 || seen_lvl !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_pulse: rise %b lvl %b want 0 / 0", seen_rise, seen_lvl);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
    int rise_cnt = 0;
    int rise_at  = -1;
    for (int i = 0; i < 5; i++) begin
      in_v[2] = pat[i];
      tick();
      n_tests++;
      if (dut_v !== exp_v) begin
        n_fail++;
        $display("FAIL bounce p%0d: got %b want %b", i, dut_v, exp_v);
      end
      if (b3.rise === 1'b1) rise_cnt++;
    end
    in_v[2] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_tests++;
      if (dut_v !== exp_v) begin
        n_fail++;
        $display("FAIL bounce e%0d: got %b want %b", e, dut_v, exp_v);
      end
      if (b3.rise === 1'b1) begin rise_cnt++; rise_at = e; end
    end
    n_tests++;
    if (rise_cnt !== 1 || rise_at !== 6) begin
      n_fail++;
      $display("FAIL bounce_rise: count %0d at %0d want 1 / 6", rise_cnt, rise_at);
    end
  endtask

  task automatic test_fall();
    int fall_at  = -1;
    int fall_cnt = 0;
    in_v[0] = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_tests++;
      if (dut_v !== exp_v) begin
        n_fail++;
        $display("FAIL fall e%0d: got %b want %b", e, dut_v, exp_v);
      end
      if (b1.fall === 1'b1) begin fall_at = e; fall_cnt++; end
    end
    n_tests++;
    if (fall_at !== 6 || fall_cnt !== 1 || b1.lvl !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_edge: at %0d count %0d lvl %b want 6 / 1 / 0",
               fall_at, fall_cnt, b1.lvl);
    end
  endtask

  task automatic test_back_to_back();
    int r1 = -1;
    int r2 = -1;
    int any_cnt = 0;
    in_v[0] = 1'b1;
    in_v[1] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_tests++;
      if (dut_v !== exp_v) begin
        n_fail++;
        $display("FAIL simul e%0d: got %b want %b", e, dut_v, exp_v);
      end
      if (b1.rise === 1'b1) r1 = e;
      if (b2.rise === 1'b1) r2 = e;
      if (any_change === 1'b1) any_cnt++;
    end
    n_tests++;
    if (r1 !== 6 || r2 !== 6 || any_cnt !== 1) begin
      n_fail++;
      $display("FAIL simul_pulse: r1 %0d r2 %0d any %0d want 6 / 6 / 1", r1, r2, any_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int r1 = -1;
    int pulses = 0;
    in_v[0] = 1'b0;
    in_v[1] = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_tests++;
      if (dut_v !== exp_v) begin
        n_fail++;
        $display("FAIL rmid_settle e%0d: got %b want %b", e, dut_v, exp_v);
      end
    end
    in_v[0] = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dut_v !== 10'b0) begin
      n_fail++;
      $display("FAIL rmid_async: got %b want %b", dut_v, 10'b0);
    end
    for (int e = 0; e < 3; e++) begin
      tick();
      if (dut_v !== 10'b0) pulses++;
    end
    rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_tests++;
      if (dut_v !== exp_v) begin
        n_fail++;
        $display("FAIL rmid_after e%0d: got %b want %b", e, dut_v, exp_v);
      end
      if (b1.rise === 1'b1) r1 = e;
    end
    n_tests++;
    if (pulses !== 0 || r1 !== 6) begin
      n_fail++;
      $display("FAIL rmid_rise: held-reset activity %0d rise at %0d want 0 / 6", pulses, r1);
    end
  endtask

  task automatic test_random();
    int hold [3];
    for (int c = 0; c < 3; c++) hold[c] = $urandom_range(1, 2 * D + 4);
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 3; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          in_v[c] = ~in_v[c];
          hold[c] = $urandom_range(1, 2 * D + 4);
        end
      end
      tick();
      n_tests++;
      if (dut_v !== exp_v) begin
        n_fail++;
        $display("FAIL random c%0d: got %b want %b", i, dut_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise_single();
    test_glitch();
    test_bounce();
    test_fall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
